// File: rtl/uart_pkg.sv
// Line-level constants and receiver state encoding shared by the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= LINE_IDLE;
      dout <= LINE_IDLE;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/assignment_9_uart_receiver.sv
// UART receiver: mid-bit sampling of a start/data/stop frame into a holding register
// with consumer handshake, framing-error and overrun pulses.
module assignment_9_uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned WORD_SIZE       = 8,
  parameter int unsigned SAMPLES_PER_BIT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_serial_in,
  input  logic                 i_read_data,
  output logic [WORD_SIZE-1:0] o_data_bus,
  output logic                 o_byte_rdy,
  output logic                 o_framing_error,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned N     = SAMPLES_PER_BIT;
  localparam int unsigned HALF  = N / 2;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned IDX_W = $clog2(WORD_SIZE + 1);

  logic                 s_in;
  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [WORD_SIZE-1:0] shift, shift_nxt;
  logic                 commit, commit_nxt;
  logic                 framing_nxt;

  uart_rx_sync u_sync (
    .clk   (i_clk),
    .reset (i_reset),
    .din   (i_serial_in),
    .dout  (s_in)
  );

  // Next-state, counters and shift register
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    commit_nxt  = 1'b0;
    framing_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (s_in == START_BIT) begin
          state_nxt = START;
          cnt_nxt   = CNT_W'(1);
        end
      end
      START: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(HALF)) begin
          if (s_in == START_BIT) begin
            state_nxt   = DATA;
            cnt_nxt     = CNT_W'(1);
            bit_idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      DATA: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(N)) begin
          // LSB-first: each new bit enters at the top and walks down
          shift_nxt   = (shift >> 1) | (WORD_SIZE'(s_in) << (WORD_SIZE - 1));
          cnt_nxt     = CNT_W'(1);
          bit_idx_nxt = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_W'(WORD_SIZE - 1)) state_nxt = STOP;
        end
      end
      STOP: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(N)) begin
          cnt_nxt = '0;
          if (s_in == STOP_BIT) begin
            commit_nxt = 1'b1;
            state_nxt  = IDLE;
          end else begin
            framing_nxt = 1'b1;
            state_nxt   = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (s_in == LINE_IDLE) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, outputs and holding register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      commit          <= 1'b0;
      o_data_bus      <= '0;
      o_byte_rdy      <= 1'b0;
      o_framing_error <= 1'b0;
      o_overrun       <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      bit_idx         <= bit_idx_nxt;
      shift           <= shift_nxt;
      commit          <= commit_nxt;
      o_framing_error <= framing_nxt;
      o_busy          <= (state_nxt != IDLE);
      // A commit takes priority over a same-cycle read
      if (commit) begin
        o_data_bus <= shift;
        o_byte_rdy <= 1'b1;
        o_overrun  <= o_byte_rdy && !i_read_data;
      end else begin
        o_overrun <= 1'b0;
        if (i_read_data) o_byte_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_assignment_9_uart_receiver.sv
// Scoreboard bench for the UART receiver: expected words are queued as frames are sent
// and popped whenever the receiver commits a word.
module tb_assignment_9_uart_receiver;

  localparam int unsigned W = 8;
  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         serial;
  logic         read;
  logic [W-1:0] data_bus;
  logic         byte_rdy;
  logic         framing_error;
  logic         overrun;
  logic         busy;

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_q[$];
  int           fe_count = 0;
  int           ov_count = 0;
  int           rdy_rise = 0;
  logic         prev_rdy = 1'b0;

  assignment_9_uart_receiver #(.WORD_SIZE(W), .SAMPLES_PER_BIT(N)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_serial_in     (serial),
    .i_read_data     (read),
    .o_data_bus      (data_bus),
    .o_byte_rdy      (byte_rdy),
    .o_framing_error (framing_error),
    .o_overrun       (overrun),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock and pop the scoreboard on every observed commit
  task automatic tick();
    logic [W-1:0] exp;
    @(negedge clk);
    if (!reset && ((byte_rdy && !prev_rdy) || overrun)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL commit_unexpected: got word %h, no word expected", data_bus);
      end else begin
        exp = exp_q.pop_front();
        if (data_bus !== exp) begin
          miscompares++;
          $display("FAIL commit_word: got %h expected %h", data_bus, exp);
        end
      end
    end
    if (framing_error === 1'b1) fe_count++;
    if (overrun === 1'b1) ov_count++;
    if (byte_rdy === 1'b1 && !prev_rdy) rdy_rise++;
    prev_rdy = (byte_rdy === 1'b1);
  endtask

  task automatic idle(input int n);
    serial = 1'b1;
    repeat (n) tick();
  endtask

  // Drives one frame in N-clock slots; slot clock c is the c-th rising edge after the start bit is driven
  task automatic send_frame(input logic [W-1:0] data, input logic stop, input int hold_low,
                            input bit push, input int reset_at, input bit check_lat);
    logic [W+1:0] bits;
    bit           aborted;
    bits    = {stop, data, 1'b0};
    aborted = 0;
    if (push) exp_q.push_back(data);
    for (int c = 0; c < int'((W + 2) * N) && !aborted; c++) begin
      if (c == reset_at) begin
        reset  = 1'b1;
        serial = 1'b1;
        tick();
        reset   = 1'b0;
        aborted = 1;
        vectors++;
        if (byte_rdy !== 1'b0 || busy !== 1'b0 || framing_error !== 1'b0 || overrun !== 1'b0) begin
          miscompares++;
          $display("FAIL midframe_reset_outputs: got rdy=%b busy=%b fe=%b ov=%b expected all 0",
                   byte_rdy, busy, framing_error, overrun);
        end
      end else begin
        serial = bits[c/N];
        if (check_lat && c == 79) begin
          vectors++;
          if (byte_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: got byte_rdy=%b at clock 78, expected 0", byte_rdy);
          end
        end
        tick();
      end
    end
    if (!aborted && check_lat) begin
      vectors++;
      if (byte_rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL latency_79: got byte_rdy=%b at clock 79, expected 1", byte_rdy);
      end
    end
    for (int i = 0; i < hold_low; i++) begin
      serial = 1'b0;
      tick();
    end
    serial = 1'b1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    serial = 1'b0;
    read   = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({data_bus, byte_rdy, framing_error, overrun, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h rdy=%b fe=%b ov=%b busy=%b expected all 0",
               data_bus, byte_rdy, framing_error, overrun, busy);
    end
    reset = 1'b0;
    idle(5);
    vectors++;
    if (busy !== 1'b0 || byte_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got busy=%b rdy=%b expected 0 0", busy, byte_rdy);
    end
  endtask

  task automatic test_single_frame();
    int fe0;
    fe0 = fe_count;
    send_frame(8'hA5, 1'b1, 0, 1, -1, 1);
    repeat (10) tick();
    vectors++;
    if (byte_rdy !== 1'b1 || data_bus !== 8'hA5) begin
      miscompares++;
      $display("FAIL frame_a5_hold: got rdy=%b data=%h expected 1 a5", byte_rdy, data_bus);
    end
    read = 1'b1;
    tick();
    read = 1'b0;
    vectors++;
    if (byte_rdy !== 1'b0 || data_bus !== 8'hA5) begin
      miscompares++;
      $display("FAIL read_clears_rdy: got rdy=%b data=%h expected 0 a5", byte_rdy, data_bus);
    end
    vectors++;
    if (fe_count != fe0) begin
      miscompares++;
      $display("FAIL frame_a5_no_fe: got %0d framing pulses expected 0", fe_count - fe0);
    end
  endtask

  task automatic test_glitch();
    int  rise0, fe0;
    bit  busy_seen;
    idle(4);
    rise0     = rdy_rise;
    fe0       = fe_count;
    busy_seen = 0;
    serial    = 1'b0;
    tick();
    tick();
    serial = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy === 1'b1) busy_seen = 1;
    end
    vectors++;
    if (!busy_seen) begin
      miscompares++;
      $display("FAIL glitch_busy: got busy never high, expected a busy period");
    end
    vectors++;
    if (busy !== 1'b0 || byte_rdy !== 1'b0 || rdy_rise != rise0 || fe_count != fe0) begin
      miscompares++;
      $display("FAIL glitch_return: got busy=%b rdy=%b rises=%0d fe=%0d expected 0 0 0 0",
               busy, byte_rdy, rdy_rise - rise0, fe_count - fe0);
    end
  endtask

  task automatic test_framing();
    int fe0;
    fe0 = fe_count;
    send_frame(8'h3C, 1'b0, 20, 0, -1, 0);
    vectors++;
    if (fe_count - fe0 != 1 || byte_rdy !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL framing_break: got fe=%0d rdy=%b busy=%b expected 1 0 1",
               fe_count - fe0, byte_rdy, busy);
    end
    idle(6);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL break_exit: got busy=%b expected 0", busy);
    end
    send_frame(8'h11, 1'b1, 0, 1, -1, 0);
    idle(2);
    vectors++;
    if (byte_rdy !== 1'b1 || data_bus !== 8'h11 || fe_count - fe0 != 1) begin
      miscompares++;
      $display("FAIL after_break_frame: got rdy=%b data=%h fe=%0d expected 1 11 1",
               byte_rdy, data_bus, fe_count - fe0);
    end
  endtask

  task automatic test_back_to_back();
    int ov0;
    read = 1'b1;
    tick();
    read = 1'b0;
    vectors++;
    if (byte_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_preclear: got rdy=%b expected 0", byte_rdy);
    end
    ov0 = ov_count;
    send_frame(8'h01, 1'b1, 0, 1, -1, 0);
    send_frame(8'hFF, 1'b1, 0, 1, -1, 0);
    idle(3);
    vectors++;
    if (ov_count - ov0 != 1 || data_bus !== 8'hFF || byte_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_overrun: got ov=%0d data=%h rdy=%b expected 1 ff 1",
               ov_count - ov0, data_bus, byte_rdy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rise0, fe0, ov0;
    read = 1'b1;
    tick();
    read  = 1'b0;
    rise0 = rdy_rise;
    fe0   = fe_count;
    ov0   = ov_count;
    send_frame(8'h77, 1'b1, 0, 0, 40, 0);
    idle(20);
    vectors++;
    if (rdy_rise != rise0 || byte_rdy !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abandoned_frame: got rises=%0d rdy=%b busy=%b expected 0 0 0",
               rdy_rise - rise0, byte_rdy, busy);
    end
    send_frame(8'h5A, 1'b1, 0, 1, -1, 0);
    idle(3);
    vectors++;
    if (byte_rdy !== 1'b1 || data_bus !== 8'h5A || fe_count != fe0 || ov_count != ov0) begin
      miscompares++;
      $display("FAIL post_reset_frame: got rdy=%b data=%h fe=%0d ov=%0d expected 1 5a 0 0",
               byte_rdy, data_bus, fe_count - fe0, ov_count - ov0);
    end
  endtask

  initial begin
    reset  = 1'b1;
    serial = 1'b0;
    read   = 1'b0;
    test_reset();
    test_single_frame();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid_frame();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d words never committed, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
